// File: rtl/pht_update_queue_pkg.sv
// Shared fetch-unit types for the PHT update queue.
// The entry struct and count typedef are sized for the default core configuration.
package pht_update_queue_pkg;

  localparam int unsigned INT_ISSUE_WIDTH         = 2;
  localparam int unsigned PHT_ENTRY_NUM_BIT_WIDTH = 10;
  localparam int unsigned PHT_ENTRY_WIDTH         = 2;
  localparam int unsigned PHT_UPDATE_QUEUE_DEPTH  = 32;

  typedef logic [$clog2(PHT_UPDATE_QUEUE_DEPTH + 1)-1:0] PhtUpdateQueueCountPath;

  typedef struct packed {
    logic                               valid;
    logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0] index;
    logic [PHT_ENTRY_WIDTH-1:0]         value;
  } PhtUpdateQueueEntry;

endpackage

// File: rtl/pht_update_queue_cam.sv
// Index CAM over the queue entries: per-query match vectors plus the youngest
// matching slot, where age is measured from the head pointer.
module pht_update_queue_cam #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned QUERIES     = 3
) (
  input  logic [DEPTH-1:0]                          valid,
  input  logic [DEPTH-1:0][INDEX_WIDTH-1:0]         index,
  input  logic [$clog2(DEPTH)-1:0]                  head,
  input  logic [QUERIES-1:0][INDEX_WIDTH-1:0]       query,
  output logic [QUERIES-1:0][DEPTH-1:0]             match,
  output logic [QUERIES-1:0]                        hit,
  output logic [QUERIES-1:0][$clog2(DEPTH)-1:0]     youngest
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] pos;

  always_comb begin
    match    = '0;
    hit      = '0;
    youngest = '0;
    pos      = '0;
    for (int unsigned q = 0; q < QUERIES; q++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        match[q][e] = valid[e] && (index[e] == query[q]);
      end
      hit[q] = |match[q];
      // Walk oldest to youngest so the last match seen is nearest the tail.
      for (int unsigned k = 0; k < DEPTH; k++) begin
        pos = head + PW'(k);
        if (match[q][pos]) begin
          youngest[q] = pos;
        end
      end
    end
  end

endmodule

// File: rtl/pht_update_queue.sv
// Multi-lane PHT update queue: circular buffer with optional same-index coalescing,
// one-per-cycle drain into the PHT write port and a pending-value lookup port.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int unsigned ENQ_WIDTH   = INT_ISSUE_WIDTH,
  parameter int unsigned QUEUE_DEPTH = PHT_UPDATE_QUEUE_DEPTH,
  parameter int unsigned INDEX_WIDTH = PHT_ENTRY_NUM_BIT_WIDTH,
  parameter int unsigned VALUE_WIDTH = PHT_ENTRY_WIDTH,
  parameter bit          COALESCE    = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ENQ_WIDTH-1:0]                  enqValid,
  input  logic [ENQ_WIDTH-1:0][INDEX_WIDTH-1:0] enqIndex,
  input  logic [ENQ_WIDTH-1:0][VALUE_WIDTH-1:0] enqValue,
  output logic                                  enqReady,
  output logic                                  deqValid,
  output logic [INDEX_WIDTH-1:0]                deqIndex,
  output logic [VALUE_WIDTH-1:0]                deqValue,
  input  logic                                  deqReady,
  input  logic [INDEX_WIDTH-1:0]                lookupIndex,
  output logic                                  lookupHit,
  output logic [VALUE_WIDTH-1:0]                lookupValue,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]      count
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned NQ = ENQ_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] ENQ_C   = CW'(ENQ_WIDTH);

  logic [QUEUE_DEPTH-1:0]                  ent_valid;
  logic [QUEUE_DEPTH-1:0][INDEX_WIDTH-1:0] ent_index;
  logic [QUEUE_DEPTH-1:0][VALUE_WIDTH-1:0] ent_value;
  logic [PW-1:0]                           head;
  logic [PW-1:0]                           tail;
  logic [CW-1:0]                           occupancy;

  logic [NQ-1:0][INDEX_WIDTH-1:0] cam_query;
  logic [NQ-1:0][QUEUE_DEPTH-1:0] cam_match;
  logic [NQ-1:0]                  cam_hit;
  logic [NQ-1:0][PW-1:0]          cam_youngest;

  logic                         enq_ready;
  logic                         deq_valid;
  logic                         pop;
  logic [QUEUE_DEPTH-1:0]       pop_mask;
  logic [CW-1:0]                space;
  logic [ENQ_WIDTH-1:0]         lane_live;
  logic [ENQ_WIDTH-1:0]         alloc_en;
  logic [ENQ_WIDTH-1:0][PW-1:0] alloc_slot;
  logic [ENQ_WIDTH-1:0]         ovw_en;
  logic [CW-1:0]                n_alloc;

  always_comb begin
    cam_query = '0;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      cam_query[i] = enqIndex[i];
    end
    cam_query[ENQ_WIDTH] = lookupIndex;
  end

  pht_update_queue_cam #(
    .DEPTH       (QUEUE_DEPTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .QUERIES     (NQ)
  ) u_cam (
    .valid    (ent_valid),
    .index    (ent_index),
    .head     (head),
    .query    (cam_query),
    .match    (cam_match),
    .hit      (cam_hit),
    .youngest (cam_youngest)
  );

  always_comb begin
    space     = DEPTH_C - occupancy;
    enq_ready = space >= ENQ_C;
    deq_valid = occupancy != '0;
    pop       = deq_valid && deqReady;
    pop_mask  = '0;
    pop_mask[head] = pop;
  end

  always_comb begin
    lane_live  = '0;
    alloc_en   = '0;
    alloc_slot = '0;
    ovw_en     = '0;
    n_alloc    = '0;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      lane_live[i] = enqValid[i] && enq_ready;
      if (COALESCE) begin
        for (int unsigned j = i + 1; j < ENQ_WIDTH; j++) begin
          if (enqValid[j] && (enqIndex[j] == enqIndex[i])) begin
            lane_live[i] = 1'b0;
          end
        end
      end
      if (lane_live[i]) begin
        // With coalescing a matching index is unique, so the CAM's youngest slot is
        // the match; a popping head is masked out and forces a fresh allocation.
        if (COALESCE && |(cam_match[i] & ~pop_mask)) begin
          ovw_en[i] = 1'b1;
        end else begin
          alloc_en[i]   = 1'b1;
          alloc_slot[i] = tail + PW'(n_alloc);
          n_alloc       = n_alloc + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
        if (alloc_en[i]) begin
          ent_valid[alloc_slot[i]] <= 1'b1;
        end
      end
      tail      <= tail + PW'(n_alloc);
      occupancy <= occupancy + n_alloc - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      if (ovw_en[i]) begin
        ent_value[cam_youngest[i]] <= enqValue[i];
      end
      if (alloc_en[i]) begin
        ent_index[alloc_slot[i]] <= enqIndex[i];
        ent_value[alloc_slot[i]] <= enqValue[i];
      end
    end
  end

  always_comb begin
    enqReady    = enq_ready;
    deqValid    = deq_valid;
    deqIndex    = deq_valid ? ent_index[head] : '0;
    deqValue    = deq_valid ? ent_value[head] : '0;
    lookupHit   = cam_hit[ENQ_WIDTH];
    lookupValue = cam_hit[ENQ_WIDTH] ? ent_value[cam_youngest[ENQ_WIDTH]] : '0;
    count       = occupancy;
  end

endmodule
